dispatch_stub: RTL and testbench



---
 rtl/dispatch_stub.sv | 101 ++++++++++
 tb/tb_dispatch_stub.sv | 142 ++++++++++++++
 2 files changed

// File: rtl/dispatch_stub.sv
// Minimal dispatch stage: classifies up to two renamed micro-ops per bundle
// into execution clusters, registers the per-lane selection and counts issues.
package uop_pkg;
   typedef logic [7:0] uop_tag_t;

   localparam uop_tag_t UOP_INT_ALU        = 8'h01;
   localparam uop_tag_t UOP_INT_SAT_ADD    = 8'h02;
   localparam uop_tag_t UOP_LD_U8          = 8'h10;
   localparam uop_tag_t UOP_LD_U32         = 8'h11;
   localparam uop_tag_t UOP_ST_U8          = 8'h18;
   localparam uop_tag_t UOP_ST_U32         = 8'h19;
   localparam uop_tag_t UOP_CAP_LOAN_BEGIN = 8'h20;
   localparam uop_tag_t UOP_CAP_JUMP       = 8'h21;
   localparam uop_tag_t UOP_CAP_RET        = 8'h22;
   localparam uop_tag_t UOP_MEM_PREFETCH   = 8'h30;
endpackage

package cluster_pkg;
   typedef enum logic [1:0] {
      CLUSTER_ALU        = 2'd0,
      CLUSTER_CAPABILITY = 2'd1,
      CLUSTER_LSQ        = 2'd2,
      CLUSTER_ASYNC      = 2'd3
   } cluster_sel_e;
endpackage

module dispatch_stub
   import uop_pkg::*;
   import cluster_pkg::*;
#(
   parameter int MAX_UOPS = 2
) (
   input  logic                  clk_i,
   input  logic                  rst_i,
   input  logic                  rename_valid_i,
   input  logic [7:0]            rename_uop0_i,
   input  logic [7:0]            rename_uop1_i,
   input  logic [1:0]            rename_uop_count_i,
   output logic                  dispatch_ready_o,
   output logic [MAX_UOPS*2-1:0] lane_cluster_o,
   output logic [15:0]           alu_issue_count_o,
   output logic [15:0]           capability_issue_count_o,
   output logic [15:0]           lsq_issue_count_o,
   output logic [15:0]           async_issue_count_o
);

   function automatic cluster_sel_e classify(input uop_tag_t tag);
      case (tag)
         UOP_LD_U8, UOP_LD_U32, UOP_ST_U8, UOP_ST_U32:       return CLUSTER_LSQ;
         UOP_CAP_LOAN_BEGIN, UOP_CAP_JUMP, UOP_CAP_RET:      return CLUSTER_CAPABILITY;
         UOP_MEM_PREFETCH:                                   return CLUSTER_ASYNC;
         default:                                            return CLUSTER_ALU;
      endcase
   endfunction

   uop_tag_t              uops [2];
   logic                  handshake;
   logic [MAX_UOPS*2-1:0] lane_next;
   logic [3:0][1:0]       inc;
   logic [MAX_UOPS*2-1:0] lane_q;
   logic [15:0]           count_q [4];
   cluster_sel_e          cls;

   assign uops[0]          = rename_uop0_i;
   assign uops[1]          = rename_uop1_i;
   assign dispatch_ready_o = 1'b1;
   assign handshake        = rename_valid_i && dispatch_ready_o;

   // Inactive lanes (beyond the bundle count or the lane budget) report ALU and count nothing.
   always_comb begin
      // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
      lane_next = '0;
      inc       = '0;
      cls       = CLUSTER_ALU;
      for (int i = 0; i < MAX_UOPS; i++) begin
         if (2'(i) < rename_uop_count_i) begin
            cls              = classify(uops[i]);
            lane_next[2*i +: 2] = cls;
            inc[cls]         = inc[cls] + 2'd1;
         end
      end
   end

   always_ff @(posedge clk_i) begin
      // NOTE: sequential state uses non-blocking assignments so all registers update together.
      if (rst_i) begin
         lane_q <= '0;
         for (int c = 0; c < 4; c++) count_q[c] <= '0;
      end else if (handshake) begin
         lane_q <= lane_next;
         for (int c = 0; c < 4; c++) count_q[c] <= count_q[c] + 16'(inc[c]);
      end
   end

   assign lane_cluster_o           = lane_q;
   assign alu_issue_count_o        = count_q[CLUSTER_ALU];
   assign capability_issue_count_o = count_q[CLUSTER_CAPABILITY];
   assign lsq_issue_count_o        = count_q[CLUSTER_LSQ];
   assign async_issue_count_o      = count_q[CLUSTER_ASYNC];

endmodule

// File: tb/tb_dispatch_stub.sv
// Table-driven bench for dispatch_stub, running a wide (2-lane) and a narrow
// (1-lane) instance side by side on the same stimulus.
module tb_dispatch_stub;
   import uop_pkg::*;

   typedef struct {
      logic            valid;
      logic [1:0]      count;
      logic [7:0]      u0;
      logic [7:0]      u1;
      logic [3:0]      w_lane;
      logic [1:0]      n_lane;
      logic [3:0][15:0] w_cnt;   // indexed alu, cap, lsq, async
      logic [3:0][15:0] n_cnt;
   } vec_t;

   logic        clk = 1'b0;
   logic        rst;
   logic        valid;
   logic [7:0]  uop0, uop1;
   logic [1:0]  count;
   logic        w_ready, n_ready;
   logic [3:0]  w_lane;
   logic [1:0]  n_lane;
   logic [15:0] w_alu, w_cap, w_lsq, w_async;
   logic [15:0] n_alu, n_cap, n_lsq, n_async;

   int n_cmp  = 0;
   int n_fail = 0;
   vec_t vecs[$];

   always #5 clk = ~clk;

   dispatch_stub #(.MAX_UOPS(2)) u_wide (
      .clk_i(clk), .rst_i(rst), .rename_valid_i(valid),
      .rename_uop0_i(uop0), .rename_uop1_i(uop1), .rename_uop_count_i(count),
      .dispatch_ready_o(w_ready), .lane_cluster_o(w_lane),
      .alu_issue_count_o(w_alu), .capability_issue_count_o(w_cap),
      .lsq_issue_count_o(w_lsq), .async_issue_count_o(w_async)
   );

   dispatch_stub #(.MAX_UOPS(1)) u_narrow (
      .clk_i(clk), .rst_i(rst), .rename_valid_i(valid),
      .rename_uop0_i(uop0), .rename_uop1_i(uop1), .rename_uop_count_i(count),
      .dispatch_ready_o(n_ready), .lane_cluster_o(n_lane),
      .alu_issue_count_o(n_alu), .capability_issue_count_o(n_cap),
      .lsq_issue_count_o(n_lsq), .async_issue_count_o(n_async)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic check_all(input string tag, input logic [3:0] wl, input logic [1:0] nl,
                            input logic [3:0][15:0] wc, input logic [3:0][15:0] nc);
      check({tag, " wide lanes"},   32'(w_lane),  32'(wl));
      check({tag, " narrow lanes"}, 32'(n_lane),  32'(nl));
      check({tag, " wide alu"},     32'(w_alu),   32'(wc[0]));
      check({tag, " wide cap"},     32'(w_cap),   32'(wc[1]));
      check({tag, " wide lsq"},     32'(w_lsq),   32'(wc[2]));
      check({tag, " wide async"},   32'(w_async), 32'(wc[3]));
      check({tag, " narrow alu"},   32'(n_alu),   32'(nc[0]));
      check({tag, " narrow cap"},   32'(n_cap),   32'(nc[1]));
      check({tag, " narrow lsq"},   32'(n_lsq),   32'(nc[2]));
      check({tag, " narrow async"}, 32'(n_async), 32'(nc[3]));
   endtask

   task automatic add(input logic v, input logic [1:0] c, input logic [7:0] a, input logic [7:0] b,
                      input logic [3:0] wl, input logic [1:0] nl,
                      input logic [3:0][15:0] wc, input logic [3:0][15:0] nc);
      vec_t x;
      x.valid = v; x.count = c; x.u0 = a; x.u1 = b;
      x.w_lane = wl; x.n_lane = nl; x.w_cnt = wc; x.n_cnt = nc;
      vecs.push_back(x);
   endtask

   initial begin
      // Expected counters are written {async, lsq, cap, alu}.
      add(1, 2'd0, UOP_CAP_RET,        UOP_CAP_RET, 4'b0000, 2'b00, {16'd0,16'd0,16'd0,16'd0}, {16'd0,16'd0,16'd0,16'd0});
      add(1, 2'd1, UOP_INT_SAT_ADD,    UOP_INT_ALU, 4'b0000, 2'b00, {16'd0,16'd0,16'd0,16'd1}, {16'd0,16'd0,16'd0,16'd1});
      add(1, 2'd1, UOP_LD_U8,          UOP_INT_ALU, 4'b0010, 2'b10, {16'd0,16'd1,16'd0,16'd1}, {16'd0,16'd1,16'd0,16'd1});
      add(1, 2'd1, UOP_CAP_LOAN_BEGIN, UOP_INT_ALU, 4'b0001, 2'b01, {16'd0,16'd1,16'd1,16'd1}, {16'd0,16'd1,16'd1,16'd1});
      add(1, 2'd1, UOP_MEM_PREFETCH,   UOP_INT_ALU, 4'b0011, 2'b11, {16'd1,16'd1,16'd1,16'd1}, {16'd1,16'd1,16'd1,16'd1});
      add(1, 2'd2, UOP_CAP_JUMP,       UOP_LD_U8,   4'b1001, 2'b01, {16'd1,16'd2,16'd2,16'd1}, {16'd1,16'd1,16'd2,16'd1});
      add(1, 2'd1, 8'hFF,              UOP_INT_ALU, 4'b0000, 2'b00, {16'd1,16'd2,16'd2,16'd2}, {16'd1,16'd1,16'd2,16'd2});
      add(0, 2'd1, UOP_LD_U8,          UOP_LD_U8,   4'b0000, 2'b00, {16'd1,16'd2,16'd2,16'd2}, {16'd1,16'd1,16'd2,16'd2});
      add(1, 2'd3, UOP_ST_U8,          UOP_ST_U32,  4'b1010, 2'b10, {16'd1,16'd4,16'd2,16'd2}, {16'd1,16'd2,16'd2,16'd2});
      add(1, 2'd2, UOP_CAP_RET,        UOP_CAP_RET, 4'b0101, 2'b01, {16'd1,16'd4,16'd4,16'd2}, {16'd1,16'd2,16'd3,16'd2});

      rst = 1'b1; valid = 1'b0; uop0 = UOP_LD_U8; uop1 = UOP_LD_U8; count = 2'd2;
      #1;
      check("ready during reset wide",   32'(w_ready), 32'd1);
      check("ready during reset narrow", 32'(n_ready), 32'd1);
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
      check_all("reset", 4'b0000, 2'b00, '0, '0);
      @(posedge clk); #1;
      check_all("idle after reset", 4'b0000, 2'b00, '0, '0);
      check("ready after reset wide",   32'(w_ready), 32'd1);
      check("ready after reset narrow", 32'(n_ready), 32'd1);

      foreach (vecs[i]) begin
         valid = vecs[i].valid; count = vecs[i].count; uop0 = vecs[i].u0; uop1 = vecs[i].u1;
         @(posedge clk); #1;
         check_all($sformatf("vec%0d", i), vecs[i].w_lane, vecs[i].n_lane, vecs[i].w_cnt, vecs[i].n_cnt);
      end

      // Reset wins over a simultaneous handshake.
      rst = 1'b1; valid = 1'b1; count = 2'd2; uop0 = UOP_LD_U8; uop1 = UOP_LD_U32;
      @(posedge clk); #1;
      check_all("reset vs handshake", 4'b0000, 2'b00, '0, '0);

      // First edge after release with valid high is a normal handshake.
      rst = 1'b0;
      @(posedge clk); #1;
      check_all("handshake at release", 4'b1010, 2'b10,
                {16'd0,16'd2,16'd0,16'd0}, {16'd0,16'd1,16'd0,16'd0});

      // Counter wrap: wide ALU gains 2 per cycle, 32768 cycles wraps it to zero.
      rst = 1'b1; valid = 1'b0;
      @(posedge clk); #1;
      rst = 1'b0; valid = 1'b1; count = 2'd2; uop0 = UOP_INT_ALU; uop1 = UOP_INT_SAT_ADD;
      for (int k = 0; k < 32768; k++) @(posedge clk);
      #1;
      check("wrap wide alu",   32'(w_alu), 32'h0000);
      check("wrap narrow alu", 32'(n_alu), 32'h8000);
      @(posedge clk); #1;
      check("post-wrap wide alu",   32'(w_alu), 32'h0002);
      check("post-wrap narrow alu", 32'(n_alu), 32'h8001);
      check("post-wrap wide lsq",   32'(w_lsq), 32'h0000);
      valid = 1'b0;

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
